// File: rtl/riscv_r_pipe.sv
// Three-stage (fetch, decode/read, execute/writeback) RV32/RV64 R-type core
// with an X-to-D bypass, a sticky illegal-instruction flag and optional MUL.
module riscv_r_pipe #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter bit              ENABLE_M = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic            retire_valid,
  output logic [XLEN-1:0] retire_pc,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic            illegal
);

  localparam int         IW = $clog2(NREGS);
  localparam int         SW = $clog2(XLEN);
  localparam logic [5:0] NR = 6'(NREGS);

  logic [XLEN-1:0]             pc;
  logic                        accept;
  logic                        d_valid;
  logic [31:0]                 d_inst;
  logic [XLEN-1:0]             d_pc;
  logic [4:0]                  d_rs1, d_rs2;
  logic [XLEN-1:0]             rf_a, rf_b, op_a, op_b;
  logic                        x_valid;
  logic [31:0]                 x_inst;
  logic [XLEN-1:0]             x_pc, x_a, x_b, x_result;
  logic [6:0]                  x_op, x_f7;
  logic [2:0]                  x_f3;
  logic [4:0]                  x_rd, x_rs1, x_rs2;
  logic [SW-1:0]               shamt;
  logic                        x_legal_op, x_regs_ok, x_legal, x_wr;
  logic [NREGS-1:0][XLEN-1:0]  regs;

  assign imem_req  = reset;
  assign imem_addr = pc;
  assign accept    = imem_req & imem_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= PC_RESET;
      d_valid <= 1'b0;
      d_inst  <= '0;
      d_pc    <= '0;
    end else begin
      d_valid <= accept;
      if (accept) begin
        pc     <= pc + XLEN'(4);
        d_inst <= imem_rdata;
        d_pc   <= pc;
      end
    end
  end

  assign d_rs1 = d_inst[19:15];
  assign d_rs2 = d_inst[24:20];

  // Out-of-range indices read as zero; X flags such instructions illegal anyway.
  always_comb begin
    rf_a = '0;
    rf_b = '0;
    if (d_rs1 != 5'd0 && {1'b0, d_rs1} < NR) rf_a = regs[d_rs1[IW-1:0]];
    if (d_rs2 != 5'd0 && {1'b0, d_rs2} < NR) rf_b = regs[d_rs2[IW-1:0]];
  end

  assign op_a = (x_wr && x_rd == d_rs1) ? x_result : rf_a;
  assign op_b = (x_wr && x_rd == d_rs2) ? x_result : rf_b;

  assign x_op  = x_inst[6:0];
  assign x_rd  = x_inst[11:7];
  assign x_f3  = x_inst[14:12];
  assign x_rs1 = x_inst[19:15];
  assign x_rs2 = x_inst[24:20];
  assign x_f7  = x_inst[31:25];
  assign shamt = x_b[SW-1:0];

  always_comb begin
    x_legal_op = 1'b0;
    if (x_op == 7'b0110011) begin
      if (x_f7 == 7'b0000000)
        x_legal_op = 1'b1;
      else if (x_f7 == 7'b0100000 && (x_f3 == 3'b000 || x_f3 == 3'b101))
        x_legal_op = 1'b1;
      else if (ENABLE_M && x_f7 == 7'b0000001 && x_f3 == 3'b000)
        x_legal_op = 1'b1;
    end
  end

  assign x_regs_ok = ({1'b0, x_rs1} < NR) && ({1'b0, x_rs2} < NR) && ({1'b0, x_rd} < NR);
  assign x_legal   = x_legal_op & x_regs_ok;
  assign x_wr      = x_valid & x_legal & (x_rd != 5'd0);

  always_comb begin
    x_result = '0;
    case (x_f3)
      3'b000: begin
        if (ENABLE_M && x_f7[0]) x_result = x_a * x_b;
        else if (x_f7[5])        x_result = x_a - x_b;
        else                     x_result = x_a + x_b;
      end
      3'b001: x_result = x_a << shamt;
      3'b010: x_result = {{(XLEN-1){1'b0}}, $signed(x_a) < $signed(x_b)};
      3'b011: x_result = {{(XLEN-1){1'b0}}, x_a < x_b};
      3'b100: x_result = x_a ^ x_b;
      3'b101: begin
        if (x_f7[5]) x_result = $signed(x_a) >>> shamt;
        else         x_result = x_a >> shamt;
      end
      3'b110: x_result = x_a | x_b;
      default: x_result = x_a & x_b;
    endcase
  end

  // Regfile write and retire report share one edge; illegal ops only raise the flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_valid      <= 1'b0;
      x_inst       <= '0;
      x_pc         <= '0;
      x_a          <= '0;
      x_b          <= '0;
      regs         <= '0;
      retire_valid <= 1'b0;
      retire_pc    <= '0;
      retire_rd    <= '0;
      retire_data  <= '0;
      illegal      <= 1'b0;
    end else begin
      x_valid      <= d_valid;
      x_inst       <= d_inst;
      x_pc         <= d_pc;
      x_a          <= op_a;
      x_b          <= op_b;
      retire_valid <= x_valid & x_legal;
      if (x_valid && x_legal) begin
        retire_pc   <= x_pc;
        retire_rd   <= x_rd;
        retire_data <= x_result;
      end
      if (x_wr) regs[x_rd[IW-1:0]] <= x_result;
      if (x_valid && !x_legal) illegal <= 1'b1;
    end
  end

endmodule
